// File: rtl/la_pkg.sv
// Shared types and constants for the logic-analyzer protocol-trigger blocks.
package la_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RX   = 1'b1
  } spi_state_t;

  localparam int SPI_LEN8  = 8;
  localparam int SPI_LEN16 = 16;
  localparam int SPI_CMP_W = SPI_LEN16;

  // Debug view: FSM state, captured word, and the edge-detect flops {ss, sclk, mosi}.
  typedef struct packed {
    spi_state_t           state;
    logic [SPI_CMP_W-1:0] shft;
    logic [2:0]           lines;
  } spi_dbg_t;

  // Masked compare: a bit matches when equal or marked don't-care.
  function automatic logic spi_hit(input logic [SPI_CMP_W-1:0] shft,
                                   input logic [SPI_CMP_W-1:0] match,
                                   input logic [SPI_CMP_W-1:0] mask,
                                   input logic                 len8);
    logic [SPI_CMP_W-1:0] eq;
    eq = ~(shft ^ match) | mask;
    return len8 ? &eq[SPI_LEN8-1:0] : &eq;
  endfunction

endpackage

// File: rtl/spi_trig_rx_if.sv
// Bundle of the monitored SPI lines, trigger configuration and trigger output.
interface spi_trig_rx_if;
  import la_pkg::*;

  // No valid/ready handshake here: SS_n/SCLK/MOSI are free-running async lines,
  // the config fields are quasi-static, and SPItrig is a one-clk pulse with no back-pressure.
  logic                 SS_n;
  logic                 SCLK;
  logic                 MOSI;
  logic                 edg;
  logic                 len8;
  logic [SPI_CMP_W-1:0] match;
  logic [SPI_CMP_W-1:0] mask;
  logic                 armed;
  logic                 SPItrig;

  modport master (output SS_n, SCLK, MOSI, edg, len8, match, mask, armed,
                  input  SPItrig);
  modport slave  (input  SS_n, SCLK, MOSI, edg, len8, match, mask, armed,
                  output SPItrig);
endinterface

// File: rtl/la_sync.sv
// Parameterized-depth synchronizer followed by one edge-detect flop.
module la_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic q_d
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= {STAGES{RST_VAL}};
      q_d <= RST_VAL;
    end else begin
      sr  <= {sr[STAGES-2:0], d};
      q_d <= sr[STAGES-1];
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/spi_trig_rx.sv
// Passive SPI receiver that pulses SPItrig when a finished transaction matches match/mask.
// Optional SPI_TRIG_LEN_CHK_EN: also require the exact bit count (8 or 16) for a hit.
module spi_trig_rx
  import la_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_trig_rx_if.slave    bus,
  output spi_dbg_t        dbg
);

  logic ss_q, ss_d, sclk_q, sclk_d, mosi_q, mosi_d;

  la_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk(clk), .rst_n(rst_n), .d(bus.SS_n), .q(ss_q), .q_d(ss_d));
  la_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(bus.SCLK), .q(sclk_q), .q_d(sclk_d));
  la_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d(bus.MOSI), .q(mosi_q), .q_d(mosi_d));

  logic ss_fall, ss_rise, sclk_sel;
  assign ss_fall  = ~ss_q & ss_d;
  assign ss_rise  = ss_q & ~ss_d;
  assign sclk_sel = bus.edg ? (sclk_q & ~sclk_d) : (~sclk_q & sclk_d);

  spi_state_t           state, state_nxt;
  logic                 start, shift_en, done, hit, trig_nxt, trig_q;
  logic [SPI_CMP_W-1:0] shft;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ss_fall) state_nxt = RX;
      RX:      if (ss_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode; entry wins over a coincident SCLK edge because shift_en needs RX.
  always_comb begin
    start    = 1'b0;
    shift_en = 1'b0;
    done     = 1'b0;
    trig_nxt = 1'b0;
    if (state == IDLE) begin
      start = ss_fall;
    end else begin
      shift_en = sclk_sel;
      done     = ss_rise;
      trig_nxt = ss_rise & hit & bus.armed;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        shft <= '0;
    else if (start)    shft <= '0;
    else if (shift_en) shft <= {shft[SPI_CMP_W-2:0], mosi_q};
  end

`ifdef SPI_TRIG_LEN_CHK_EN
  logic [4:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       cnt <= '0;
    else if (start)                   cnt <= '0;
    else if (shift_en && cnt != 5'd31) cnt <= cnt + 5'd1;
  end

  assign hit = spi_hit(shft, bus.match, bus.mask, bus.len8) &&
               (cnt == (bus.len8 ? 5'(SPI_LEN8) : 5'(SPI_LEN16)));
`else
  assign hit = spi_hit(shft, bus.match, bus.mask, bus.len8);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trig_q <= 1'b0;
    else        trig_q <= trig_nxt;
  end

  assign bus.SPItrig = trig_q;

  assign dbg.state = state;
  assign dbg.shft  = shft;
  assign dbg.lines = {ss_d, sclk_d, mosi_d};

endmodule

// File: tb/tb_spi_trig_rx.sv
// Directed bench for spi_trig_rx: vector table plus reset/gating sequences.
module tb_spi_trig_rx;
  import la_pkg::*;

  localparam int SYNC_STAGES = 2;
`ifdef SPI_TRIG_LEN_CHK_EN
  localparam bit LENCHK = 1'b1;
`else
  localparam bit LENCHK = 1'b0;
`endif

  logic     clk;
  logic     rst_n;
  spi_dbg_t dbg;

  spi_trig_rx_if bus();

  spi_trig_rx #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .dbg(dbg));

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pulse_cnt = 0;
  int last_pulse_cyc = 0;
  int rise_cyc = 0;
  always @(negedge clk) begin
    if (bus.SPItrig === 1'b1) begin
      pulse_cnt      = pulse_cnt + 1;
      last_pulse_cyc = cyc;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic pos);
    if (pos) begin
      bus.SCLK = 1'b0; bus.MOSI = b; clks(4);
      bus.SCLK = 1'b1; clks(4);
    end else begin
      bus.MOSI = b; clks(4);
      bus.SCLK = 1'b0; clks(4);
      bus.SCLK = 1'b1;
    end
  endtask

  task automatic xfer(input logic [15:0] data, input int nbits, input logic pos);
    bus.SS_n = 1'b0;
    clks(4);
    for (int i = nbits - 1; i >= 0; i--) send_bit(data[i], pos);
    clks(4);
    bus.SS_n = 1'b1;
    rise_cyc = cyc;
  endtask

  typedef struct {
    string       name;
    logic [15:0] data;
    int          nbits;
    logic        edg;
    logic        len8;
    logic [15:0] match;
    logic [15:0] mask;
    logic        armed;
    int          exp_p;
    logic [15:0] exp_shft;
  } vec_t;

  vec_t vecs[11];

  task automatic run_vec(input vec_t v);
    int p0;
    bus.edg = v.edg; bus.len8 = v.len8; bus.match = v.match;
    bus.mask = v.mask; bus.armed = v.armed;
    p0 = pulse_cnt;
    xfer(v.data, v.nbits, v.edg);
    clks(12);
    chk({v.name, "_pulses"}, pulse_cnt - p0, v.exp_p);
    if (v.exp_p == 1) chk({v.name, "_latency"}, last_pulse_cyc - rise_cyc, SYNC_STAGES + 1);
    chk({v.name, "_state"}, 32'(dbg.state), 32'(IDLE));
    chk({v.name, "_shft"}, dbg.shft, v.exp_shft);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int p0;
    rst_n = 1'b0;
    bus.SS_n = 1'b1; bus.SCLK = 1'b1; bus.MOSI = 1'b0;
    bus.edg = 1'b0; bus.len8 = 1'b1; bus.match = 16'h0000;
    bus.mask = 16'h0000; bus.armed = 1'b1;

    vecs[0]  = '{"m8_match",   16'h0066,  8, 1'b0, 1'b1, 16'h0066, 16'h0000, 1'b1, 1, 16'h0066};
    vecs[1]  = '{"m8_miss",    16'h0066,  8, 1'b0, 1'b1, 16'h0067, 16'h0000, 1'b1, 0, 16'h0066};
    vecs[2]  = '{"m8_mask",    16'h0066,  8, 1'b0, 1'b1, 16'h0067, 16'h0001, 1'b1, 1, 16'h0066};
    vecs[3]  = '{"m16_lowdc",  16'hA512, 16, 1'b1, 1'b0, 16'hA5C3, 16'h00FF, 1'b1, 1, 16'hA512};
    vecs[4]  = '{"m16_miss",   16'hA4C3, 16, 1'b1, 1'b0, 16'hA5C3, 16'h00FF, 1'b1, 0, 16'hA4C3};
    vecs[5]  = '{"disarmed",   16'h0066,  8, 1'b0, 1'b1, 16'h0066, 16'h0000, 1'b0, 0, 16'h0066};
    vecs[6]  = '{"short7",     16'h0000,  7, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, LENCHK ? 0 : 1, 16'h0000};
    vecs[7]  = '{"full8_zero", 16'h0000,  8, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b1, 1, 16'h0000};
    vecs[8]  = '{"long12",     16'h0F66, 12, 1'b0, 1'b1, 16'h0066, 16'h0000, 1'b1, LENCHK ? 0 : 1, 16'h0F66};
    vecs[9]  = '{"short16",    16'h0066,  8, 1'b1, 1'b0, 16'h0066, 16'h0000, 1'b1, LENCHK ? 0 : 1, 16'h0066};
    vecs[10] = '{"m16_neg",    16'h1234, 16, 1'b0, 1'b0, 16'h1234, 16'h0000, 1'b1, 1, 16'h1234};

    clks(3);
    chk("rst_trig", bus.SPItrig, 1'b0);
    chk("rst_state", 32'(dbg.state), 32'(IDLE));
    chk("rst_shft", dbg.shft, 16'h0000);
    rst_n = 1'b1;
    clks(4);

    // SCLK activity with SS_n high must be ignored.
    p0 = pulse_cnt;
    bus.MOSI = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.SCLK = ~bus.SCLK;
      clks(4);
    end
    clks(8);
    chk("gate_state", 32'(dbg.state), 32'(IDLE));
    chk("gate_shft", dbg.shft, 16'h0000);
    chk("gate_pulses", pulse_cnt - p0, 0);

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // Reset in the middle of a matching transfer, then a fresh full transfer.
    bus.edg = 1'b0; bus.len8 = 1'b1; bus.match = 16'h0066;
    bus.mask = 16'h0000; bus.armed = 1'b1;
    p0 = pulse_cnt;
    bus.SS_n = 1'b0;
    clks(4);
    for (int i = 7; i > 3; i--) send_bit(1'(8'h66 >> i), 1'b0);
    clks(4);
    chk("mid_state", 32'(dbg.state), 32'(RX));
    chk("mid_shft", dbg.shft, 16'h0006);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_trig", bus.SPItrig, 1'b0);
    chk("mid_rst_state", 32'(dbg.state), 32'(IDLE));
    chk("mid_rst_shft", dbg.shft, 16'h0000);
    bus.SS_n = 1'b1; bus.SCLK = 1'b1;
    clks(3);
    rst_n = 1'b1;
    clks(8);
    chk("mid_rst_pulses", pulse_cnt - p0, 0);
    xfer(16'h0066, 8, 1'b0);
    clks(12);
    chk("after_rst_pulses", pulse_cnt - p0, 1);
    chk("after_rst_latency", last_pulse_cyc - rise_cyc, SYNC_STAGES + 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
